// File: rtl/piso_tx_sched.sv
// Two-requester round-robin scheduler feeding a 128-bit PISO.
// Each granted block is loaded once, shifted for 128 cycles, then followed by an idle gap.
module piso_tx_sched #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  input  logic         flush,
  output logic         piso_wr_en,
  output logic [127:0] piso_data,
  output logic         ser_valid,
  output logic         ser_first,
  output logic         ser_last,
  output logic         ser_src,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  localparam logic [6:0] LAST_BIT = 7'd127;
  localparam logic [6:0] GAP_LAST = (GAP_CYCLES == 0) ? 7'd0 : 7'(GAP_CYCLES - 1);
  // A frame that ends or aborts skips the gap entirely when GAP_CYCLES is zero.
  localparam state_t     END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic       END_BUSY  = (GAP_CYCLES != 0);

  state_t     state_reg;
  logic [6:0] cnt_reg;
  logic       last_reg;

  logic any_valid;
  logic grant_idx;
  logic in_idle;

  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_idx = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_idx = ~last_reg;
    end
  end

  assign in_idle    = (state_reg == IDLE);
  assign req0_ready = in_idle & any_valid & ~grant_idx;
  assign req1_ready = in_idle & any_valid & grant_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      piso_data  <= '0;
      piso_wr_en <= 1'b0;
      ser_valid  <= 1'b0;
      ser_first  <= 1'b0;
      ser_last   <= 1'b0;
      ser_src    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            piso_data  <= grant_idx ? req1_data : req0_data;
            ser_src    <= grant_idx;
            last_reg   <= grant_idx;
            piso_wr_en <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= LOAD;
          end
        end

        LOAD: begin
          piso_wr_en <= 1'b0;
          cnt_reg    <= '0;
          if (flush) begin
            state_reg <= END_STATE;
            busy      <= END_BUSY;
          end else begin
            ser_valid <= 1'b1;
            ser_first <= 1'b1;
            ser_last  <= 1'b0;
            state_reg <= SHIFT;
          end
        end

        SHIFT: begin
          // flush wins over the final count so an aborted frame never shows ser_last
          if (flush || cnt_reg == LAST_BIT) begin
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= END_STATE;
            busy      <= END_BUSY;
          end else begin
            cnt_reg   <= cnt_reg + 7'd1;
            ser_first <= 1'b0;
            ser_last  <= (cnt_reg == LAST_BIT - 7'd1);
          end
        end

        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched: scoreboard of granted blocks checked against a PISO model,
// plus cycle-exact handshake spacing, flush, mid-frame reset and a zero-gap build.
module tb_piso_tx_sched;

  localparam logic [127:0] P_A5   = {16{8'hA5}};
  localparam logic [127:0] P_ZERO = '0;
  localparam logic [127:0] P_ONES = '1;
  localparam logic [127:0] P_CNT  = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid, flush, g0_valid;
  logic [127:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, piso_wr_en, ser_valid, ser_first, ser_last, ser_src, busy;
  logic [127:0] piso_data;
  logic         g0_req0_ready, g0_req1_ready, g0_wr_en, g0_ser_valid, g0_ser_first, g0_ser_last;
  logic         g0_ser_src, g0_busy;
  logic [127:0] g0_piso_data;

  typedef struct packed {
    logic [127:0] data;
    logic         src;
  } exp_t;
  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_tx_sched #(.GAP_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .flush(flush), .piso_wr_en(piso_wr_en), .piso_data(piso_data),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
    .ser_src(ser_src), .busy(busy)
  );

  piso_tx_sched #(.GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(g0_valid), .req0_data(req0_data), .req0_ready(g0_req0_ready),
    .req1_valid(1'b0), .req1_data(req1_data), .req1_ready(g0_req1_ready),
    .flush(1'b0), .piso_wr_en(g0_wr_en), .piso_data(g0_piso_data),
    .ser_valid(g0_ser_valid), .ser_first(g0_ser_first), .ser_last(g0_ser_last),
    .ser_src(g0_ser_src), .busy(g0_busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Waits for a grant on the main DUT, records the handshake cycle and queues the expected block.
  task automatic wait_grant(input logic exp_src, input int limit, output int t);
    int n;
    exp_t e;
    n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < limit) begin
      step(1);
      n++;
    end
    t = cyc;
    chk("grant_in_time", n < limit, 1);
    chk("grant_src", req1_ready, exp_src);
    chk("grant_onehot", req0_ready & req1_ready, 0);
    e.data = exp_src ? req1_data : req0_data;
    e.src  = exp_src;
    sb_q.push_back(e);
    step(1);
  endtask

  task automatic wait_g0(input int limit, output int t);
    int n;
    n = 0;
    #1;
    while (!g0_req0_ready && n < limit) begin
      step(1);
      n++;
    end
    t = cyc;
    chk("g0_grant_in_time", n < limit, 1);
    step(1);
  endtask

  // PISO model and serial monitor: sampled on the falling edge, loaded/shifted as the real PISO would be.
  logic [127:0] model_reg = '0;
  logic [127:0] rx_word   = '0;
  int           nbits     = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_reg = '0;
        nbits     = 0;
      end else begin
        if (ser_valid) begin
          if (ser_first) nbits = 0;
          rx_word = {rx_word[126:0], model_reg[127]};
          nbits++;
          if (ser_last) begin
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              chk("ser_word", rx_word, e.data);
              chk("ser_src", ser_src, e.src);
              chk("ser_bits", nbits, 128);
            end
          end
        end
        if (piso_wr_en) model_reg = piso_data;
        else            model_reg = model_reg << 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;
    exp_t dropped;
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; g0_valid = 1'b0;
    req0_data = P_A5; req1_data = P_ONES;

    // Reset state
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", piso_wr_en, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_piso_data", piso_data, P_ZERO);
    chk("rst_ser_src", ser_src, 0);
    chk("rst_g0_busy", g0_busy, 0);
    reset_n = 1'b1;
    step(1);

    // Single request, full frame timing
    req0_valid = 1'b1;
    wait_grant(1'b0, 5, t0);
    req0_valid = 1'b0;
    chk("load_wr_en", piso_wr_en, 1);
    chk("load_ready", req0_ready, 0);
    chk("load_data", piso_data, P_A5);
    chk("load_busy", busy, 1);
    step(1);
    chk("shift_first", ser_first, 1);
    chk("shift_valid", ser_valid, 1);
    chk("shift_wr_en", piso_wr_en, 0);
    chk("shift_src", ser_src, 0);
    step(126);
    chk("bit126_last", ser_last, 0);
    chk("bit126_valid", ser_valid, 1);
    step(1);
    chk("bit127_last", ser_last, 1);
    chk("bit127_first", ser_first, 0);
    step(1);
    chk("gap_valid", ser_valid, 0);
    chk("gap_busy", busy, 1);
    step(1);
    chk("gap2_busy", busy, 1);
    step(1);
    chk("idle_busy", busy, 0);
    chk("hold_data", piso_data, P_A5);

    // Contention from a fresh reset: grants alternate 0,1,0,1 spaced 132 cycles
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    req0_data = P_ZERO; req1_data = P_ONES;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grant(1'b0, 5, t0);
    req0_data = P_CNT;
    wait_grant(1'b1, 300, t1);
    chk("spacing_01", t1 - t0, 132);
    req1_data = P_A5;
    wait_grant(1'b0, 300, t2);
    chk("spacing_12", t2 - t1, 132);
    wait_grant(1'b1, 300, t3);
    chk("spacing_23", t3 - t2, 132);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Flush at shift count 40, held into the gap where it must be ignored
    req0_data = P_ONES;
    req0_valid = 1'b1;
    wait_grant(1'b0, 300, t0);
    step(41);
    chk("pre_flush_valid", ser_valid, 1);
    flush = 1'b1;
    step(1);
    chk("flush_valid", ser_valid, 0);
    chk("flush_last", ser_last, 0);
    chk("flush_wr_en", piso_wr_en, 0);
    chk("flush_busy", busy, 1);
    dropped = sb_q.pop_back();
    step(1);
    flush = 1'b0;
    chk("flush_gap_busy", busy, 1);
    req0_data = P_CNT;
    wait_grant(1'b0, 10, t1);
    chk("flush_regrant", t1 - t0, 45);
    req0_valid = 1'b0;

    // Reset pulse at shift count 64
    step(65);
    chk("pre_rst_valid", ser_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", ser_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", piso_data, P_ZERO);
    chk("mid_rst_first", ser_first, 0);
    dropped = sb_q.pop_back();
    step(1);
    reset_n = 1'b1;
    req1_data = P_ONES;
    req1_valid = 1'b1;
    wait_grant(1'b1, 5, t0);
    req0_data = P_A5;
    req0_valid = 1'b1;
    wait_grant(1'b0, 300, t1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(135);
    chk("sb_drained", sb_q.size(), 0);
    chk("end_busy", busy, 0);

    // Zero-gap build: back-to-back frames 130 cycles apart
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    g0_valid = 1'b1;
    wait_g0(5, t0);
    wait_g0(200, t1);
    chk("g0_spacing_1", t1 - t0, 130);
    wait_g0(200, t2);
    chk("g0_spacing_2", t2 - t1, 130);
    g0_valid = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
